// File: rtl/glitcbus_space_decoder.sv
// GLITCBUS address-space decoder: maps bus addresses onto aliased physical slave slots,
// issues single-cycle writes, and runs ack-terminated reads with a bounded wait.
module glitcbus_space_decoder #(
  parameter int unsigned         NSLOTS    = 8,
  parameter int unsigned         SLOT_BITS = 4,
  parameter logic [4*NSLOTS-1:0] ALIAS_MAP = 32'h3254_3210,
  parameter int unsigned         TIMEOUT   = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [15:0]            adr_i,
  input  logic [31:0]            dat_i,
  input  logic                   wr_i,
  input  logic                   rd_i,
  output logic [31:0]            dat_o,
  output logic                   rd_valid_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic [7:0]             drop_cnt_o,
  output logic [NSLOTS-1:0]      slv_sel_o,
  output logic [SLOT_BITS-1:0]   slv_adr_o,
  output logic [31:0]            slv_dat_o,
  output logic                   slv_wr_o,
  output logic                   slv_rd_o,
  input  logic [32*NSLOTS-1:0]   slv_dat_i,
  input  logic [NSLOTS-1:0]      slv_ack_i
);

  localparam int unsigned IDX_BITS = $clog2(NSLOTS);
  localparam int unsigned MAP_LSB  = SLOT_BITS + IDX_BITS;

  // state      | meaning
  // IDLE       | waiting for a strobe
  // WRITE      | one-cycle slave write (no strobe if unmapped)
  // READ_WAIT  | slave selected, waiting for ack or timeout
  // RESP       | read response cycle
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_RESP
  } state_t;

  state_t                state_q;
  logic [IDX_BITS-1:0]   tgt_q;
  logic [15:0]           adr_q;
  logic [7:0]            cnt_q;
  logic                  mapped_q;
  logic                  late_q;
  logic [31:0]           dat_q;
  logic                  rd_valid_q;
  logic                  err_q;
  logic [7:0]            drop_q;
  logic [NSLOTS-1:0]     sel_q;
  logic [SLOT_BITS-1:0]  slv_adr_q;
  logic [31:0]           slv_dat_q;
  logic                  slv_wr_q;
  logic                  slv_rd_q;

  logic [IDX_BITS-1:0]   dec_slot_d;
  logic [3:0]            tgt_nib_d;
  logic [IDX_BITS-1:0]   tgt_d;
  logic                  mapped_d;
  logic [NSLOTS-1:0]     sel_d;
  logic [1:0]            drop_inc_d;
  logic [8:0]            drop_sum_d;
  logic [7:0]            drop_d;

  assign dec_slot_d = adr_i[SLOT_BITS +: IDX_BITS];
  assign tgt_nib_d  = ALIAS_MAP[{dec_slot_d, 2'b00} +: 4];
  assign tgt_d      = tgt_nib_d[IDX_BITS-1:0];
  assign mapped_d   = ((adr_i >> MAP_LSB) == 16'd0) && ({1'b0, tgt_nib_d} < 5'(NSLOTS));
  assign sel_d      = NSLOTS'(1) << tgt_d;

  // A simultaneous wr/rd in IDLE costs one drop (the read); while busy every strobe counts.
  always_comb begin
    drop_inc_d = 2'd0;
    if (state_q != ST_IDLE) begin
      drop_inc_d = {1'b0, wr_i} + {1'b0, rd_i};
    end else begin
      drop_inc_d = {1'b0, wr_i & rd_i};
    end
    drop_sum_d = {1'b0, drop_q} + {7'd0, drop_inc_d};
    drop_d     = drop_sum_d[8] ? 8'hFF : drop_sum_d[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tgt_q      <= '0;
      adr_q      <= '0;
      cnt_q      <= '0;
      mapped_q   <= 1'b0;
      late_q     <= 1'b0;
      dat_q      <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= '0;
      sel_q      <= '0;
      slv_adr_q  <= '0;
      slv_dat_q  <= '0;
      slv_wr_q   <= 1'b0;
      slv_rd_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      slv_wr_q   <= 1'b0;
      slv_rd_q   <= 1'b0;
      drop_q     <= drop_d;
      unique case (state_q)
        ST_IDLE: begin
          if (wr_i) begin
            state_q   <= ST_WRITE;
            adr_q     <= adr_i;
            mapped_q  <= mapped_d;
            slv_adr_q <= adr_i[SLOT_BITS-1:0];
            slv_dat_q <= dat_i;
            if (mapped_d) begin
              sel_q    <= sel_d;
              slv_wr_q <= 1'b1;
            end
          end else if (rd_i) begin
            adr_q     <= adr_i;
            tgt_q     <= tgt_d;
            slv_adr_q <= adr_i[SLOT_BITS-1:0];
            if (mapped_d) begin
              state_q  <= ST_READ_WAIT;
              sel_q    <= sel_d;
              slv_rd_q <= 1'b1;
              cnt_q    <= '0;
              late_q   <= 1'b0;
            end else begin
              // Unmapped read: the response is emitted as RESP exits, two cycles after rd_i.
              state_q <= ST_RESP;
              late_q  <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          sel_q   <= '0;
          err_q   <= ~mapped_q;
          state_q <= ST_IDLE;
        end
        ST_READ_WAIT: begin
          if (slv_ack_i[tgt_q]) begin
            dat_q      <= slv_dat_i[{tgt_q, 5'b00000} +: 32];
            err_q      <= 1'b0;
            rd_valid_q <= 1'b1;
            sel_q      <= '0;
            state_q    <= ST_RESP;
          end else if (cnt_q == 8'(TIMEOUT)) begin
            dat_q      <= {16'hDEAD, adr_q};
            err_q      <= 1'b1;
            rd_valid_q <= 1'b1;
            sel_q      <= '0;
            state_q    <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_RESP: begin
          if (late_q) begin
            dat_q      <= {16'hDEAD, adr_q};
            err_q      <= 1'b1;
            rd_valid_q <= 1'b1;
          end
          late_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dat_o      = dat_q;
  assign rd_valid_o = rd_valid_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign drop_cnt_o = drop_q;
  assign slv_sel_o  = sel_q;
  assign slv_adr_o  = slv_adr_q;
  assign slv_dat_o  = slv_dat_q;
  assign slv_wr_o   = slv_wr_q;
  assign slv_rd_o   = slv_rd_q;

endmodule

// File: tb/tb_glitcbus_space_decoder.sv
// Bench for glitcbus_space_decoder: a per-cycle timeline of expected outputs, filled in
// transaction by transaction from the decode rules, checked every cycle plus literal checks.
module tb_glitcbus_space_decoder;

  localparam int NS = 8;
  localparam int SB = 4;
  localparam int IB = 3;
  localparam int TO = 15;
  localparam logic [31:0] AM = 32'h3254_3210;
  localparam int SZ = 4096;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [15:0]       adr_i;
  logic [31:0]       dat_i;
  logic              wr_i, rd_i;
  logic [31:0]       dat_o;
  logic              rd_valid_o, err_o, busy_o;
  logic [7:0]        drop_cnt_o;
  logic [NS-1:0]     slv_sel_o;
  logic [SB-1:0]     slv_adr_o;
  logic [31:0]       slv_dat_o;
  logic              slv_wr_o, slv_rd_o;
  logic [32*NS-1:0]  slv_dat_i;
  logic [NS-1:0]     slv_ack_i;

  glitcbus_space_decoder dut (
    .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .wr_i(wr_i), .rd_i(rd_i),
    .dat_o(dat_o), .rd_valid_o(rd_valid_o), .err_o(err_o), .busy_o(busy_o),
    .drop_cnt_o(drop_cnt_o), .slv_sel_o(slv_sel_o), .slv_adr_o(slv_adr_o),
    .slv_dat_o(slv_dat_o), .slv_wr_o(slv_wr_o), .slv_rd_o(slv_rd_o),
    .slv_dat_i(slv_dat_i), .slv_ack_i(slv_ack_i)
  );

  always #5 clk_i = ~clk_i;

  bit          e_busy [SZ];
  bit          e_valid[SZ];
  bit          e_wr   [SZ];
  bit          e_rd   [SZ];
  bit [7:0]    e_sel  [SZ];
  bit [3:0]    e_adr  [SZ];
  bit [31:0]   e_wdat [SZ];
  bit          dat_set[SZ];
  bit [31:0]   dat_val[SZ];
  bit          err_set[SZ];
  bit          err_val[SZ];
  bit [7:0]    drop_exp[SZ];
  bit [7:0]    blk[SZ];
  bit [7:0]    drv[SZ];

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          n_checks = 0;
  int          ovr_c = -1;
  logic [7:0]  force_ack = '0;
  logic [31:0] m_dat = '0;
  logic        m_err = 1'b0;

  function automatic int phys_of(logic [15:0] a);
    int slot;
    slot = int'(a >> SB) % NS;
    return int'((AM >> (4 * slot)) & 32'hF);
  endfunction

  function automatic bit is_mapped(logic [15:0] a);
    return ((a >> (SB + IB)) == 16'd0) && (phys_of(a) < NS);
  endfunction

  function automatic logic [31:0] lane_data(int k, int c);
    if (k == 2 && c == ovr_c) return 32'h12345678;
    return (32'(c) * 32'h9E3779B1) ^ (32'(k) * 32'h01000193) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_cycle(input int c);
    if (dat_set[c]) m_dat = dat_val[c];
    if (err_set[c]) m_err = err_val[c];
    chk("busy", 32'(busy_o), 32'(e_busy[c]));
    chk("rd_valid", 32'(rd_valid_o), 32'(e_valid[c]));
    chk("slv_sel", 32'(slv_sel_o), 32'(e_sel[c]));
    chk("slv_wr", 32'(slv_wr_o), 32'(e_wr[c]));
    chk("slv_rd", 32'(slv_rd_o), 32'(e_rd[c]));
    chk("drop_cnt", 32'(drop_cnt_o), 32'(drop_exp[c]));
    chk("dat", dat_o, m_dat);
    chk("err", 32'(err_o), 32'(m_err));
    if (e_wr[c]) chk("slv_dat", slv_dat_o, e_wdat[c]);
    if (e_sel[c] != 8'd0) chk("slv_adr", 32'(slv_adr_o), 32'(e_adr[c]));
  endtask

  task automatic do_reset(input int c);
    for (int k = c + 1; k < c + 41 && k < SZ; k++) begin
      e_busy[k] = 0; e_valid[k] = 0; e_wr[k] = 0; e_rd[k] = 0; e_sel[k] = 0;
      dat_set[k] = 0; err_set[k] = 0; blk[k] = 0; drv[k] = 0;
    end
    dat_set[c+1] = 1; dat_val[c+1] = '0;
    err_set[c+1] = 1; err_val[c+1] = 1'b0;
    drop_exp[c+1] = '0;
  endtask

  task automatic plan_write(input int c, input logic [15:0] a, input logic [31:0] d);
    e_busy[c+1] = 1;
    if (is_mapped(a)) begin
      e_sel[c+1] = 8'(1 << phys_of(a)); e_wr[c+1] = 1;
      e_adr[c+1] = a[3:0]; e_wdat[c+1] = d;
    end
    err_set[c+2] = 1; err_val[c+2] = !is_mapped(a);
  endtask

  task automatic plan_read(input int c, input logic [15:0] a, input int ackd_in);
    int ph, n, ackd;
    bit acked;
    if (!is_mapped(a)) begin
      e_busy[c+1] = 1;
      e_valid[c+2] = 1;
      dat_set[c+2] = 1; dat_val[c+2] = {16'hDEAD, a};
      err_set[c+2] = 1; err_val[c+2] = 1'b1;
    end else begin
      ph = phys_of(a);
      ackd = (ackd_in < 0) ? int'($urandom_range(0, TO + 4)) : ackd_in;
      acked = (ackd <= TO);
      n = acked ? ackd : TO;
      for (int k = c + 1; k <= c + 1 + n; k++) begin
        e_busy[k] = 1; e_sel[k] = 8'(1 << ph); e_adr[k] = a[3:0];
        blk[k] = blk[k] | 8'(1 << ph);
      end
      e_rd[c+1] = 1;
      if (acked) drv[c+1+ackd] = drv[c+1+ackd] | 8'(1 << ph);
      e_busy[c+2+n] = 1;
      e_valid[c+2+n] = 1;
      dat_set[c+2+n] = 1;
      dat_val[c+2+n] = acked ? lane_data(ph, c + 1 + ackd) : {16'hDEAD, a};
      err_set[c+2+n] = 1; err_val[c+2+n] = !acked;
    end
  endtask

  task automatic step(input bit w, input bit r, input logic [15:0] a, input logic [31:0] d,
                      input bit rs, input int ackd);
    int c, nd;
    c = cyc;
    check_cycle(c);
    if (rs) begin
      do_reset(c);
    end else begin
      nd = int'(drop_exp[c]);
      if (e_busy[c]) nd = nd + int'(w) + int'(r);
      else if (w && r) nd = nd + 1;
      drop_exp[c+1] = (nd > 255) ? 8'd255 : 8'(nd);
      if (!e_busy[c]) begin
        if (w) plan_write(c, a, d);
        else if (r) plan_read(c, a, ackd);
      end
    end
    wr_i = w; rd_i = r; adr_i = a; dat_i = d; rst_i = rs;
    for (int k = 0; k < NS; k++) slv_dat_i[32*k +: 32] = lane_data(k, c);
    slv_ack_i = (8'($urandom) & ~blk[c]) | drv[c] | force_ack;
    force_ack = '0;
    vectors++;
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 16'h0, 32'h0, 0, -1);
  endtask

  initial begin
    int t, cnt;
    logic [15:0] ra;
    for (int k = 0; k < SZ; k++) begin
      e_busy[k] = 0; e_valid[k] = 0; e_wr[k] = 0; e_rd[k] = 0; e_sel[k] = 0; e_adr[k] = 0;
      e_wdat[k] = 0; dat_set[k] = 0; dat_val[k] = 0; err_set[k] = 0; err_val[k] = 0;
      drop_exp[k] = 0; blk[k] = 0; drv[k] = 0;
    end
    rst_i = 1'b1; wr_i = 0; rd_i = 0; adr_i = '0; dat_i = '0; slv_dat_i = '0; slv_ack_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);

    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_dat", dat_o, 32'd0);
    chk("reset_drop", 32'(drop_cnt_o), 32'd0);
    chk("reset_sel", 32'(slv_sel_o), 32'd0);
    idle(2);

    // Read 0x0023, slot 2 acks immediately with 0x12345678
    t = cyc; ovr_c = t + 1;
    step(0, 1, 16'h0023, 32'h0, 0, 0);
    chk("r38_sel", 32'(slv_sel_o), 32'h04);
    chk("r38_rd", 32'(slv_rd_o), 32'd1);
    idle(1);
    chk("r38_valid", 32'(rd_valid_o), 32'd1);
    chk("r38_dat", dat_o, 32'h12345678);
    chk("r38_err", 32'(err_o), 32'd0);
    idle(2);

    // Aliased read 0x0061 lands on physical slot 2
    step(0, 1, 16'h0061, 32'h0, 0, 2);
    chk("r39_sel", 32'(slv_sel_o), 32'h04);
    chk("r39_adr", 32'(slv_adr_o), 32'd1);
    idle(6);

    // Read 0x0030, slot 3 silent: timeout
    step(0, 1, 16'h0030, 32'h0, 0, 99);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy_o) cnt++;
      idle(1);
    end
    chk("r40_busy_cycles", 32'(cnt), 32'd17);
    chk("r40_dat", dat_o, 32'hDEAD0030);
    chk("r40_err", 32'(err_o), 32'd1);

    // Unmapped write then mapped write
    step(1, 0, 16'h0105, 32'hA5A5A5A5, 0, -1);
    chk("r41_no_wr", 32'(slv_wr_o), 32'd0);
    chk("r41_busy", 32'(busy_o), 32'd1);
    idle(1);
    chk("r41_err1", 32'(err_o), 32'd1);
    step(1, 0, 16'h0012, 32'hCAFEF00D, 0, -1);
    chk("r41_wr", 32'(slv_wr_o), 32'd1);
    chk("r41_sel", 32'(slv_sel_o), 32'h02);
    idle(1);
    chk("r41_err0", 32'(err_o), 32'd0);
    idle(1);

    // Simultaneous strobes and drops while busy, then saturation
    step(0, 0, 16'h0, 32'h0, 1, -1);
    step(1, 1, 16'h0012, 32'h11112222, 0, -1);
    chk("r42_wr", 32'(slv_wr_o), 32'd1);
    step(0, 1, 16'h0030, 32'h0, 0, -1);
    step(0, 1, 16'h0030, 32'h0, 0, 99);
    step(0, 1, 16'h0030, 32'h0, 0, -1);
    step(0, 1, 16'h0030, 32'h0, 0, -1);
    chk("r42_drop4", 32'(drop_cnt_o), 32'd4);
    for (int i = 0; i < 220; i++) step(1, 1, 16'h0012, 32'(i), 0, -1);
    chk("r42_sat", 32'(drop_cnt_o), 32'd255);
    idle(20);

    // Reset in the 3rd READ_WAIT cycle, late ack afterwards
    step(0, 0, 16'h0, 32'h0, 1, -1);
    step(0, 1, 16'h0030, 32'h0, 0, 99);
    idle(2);
    step(0, 0, 16'h0, 32'h0, 1, -1);
    chk("r43_busy", 32'(busy_o), 32'd0);
    chk("r43_sel", 32'(slv_sel_o), 32'd0);
    chk("r43_dat", dat_o, 32'd0);
    chk("r43_err", 32'(err_o), 32'd0);
    chk("r43_drop", 32'(drop_cnt_o), 32'd0);
    idle(1);
    force_ack = 8'h08;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (rd_valid_o) cnt++;
    end
    chk("r43_no_valid", 32'(cnt), 32'd0);
    chk("r43_idle", 32'(busy_o), 32'd0);

    // Randomized traffic
    while (cyc < SZ - 64) begin
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {9'd0, 7'($urandom)};
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, ra, $urandom,
           $urandom_range(0, 199) == 0, -1);
    end
    check_cycle(cyc);

    if (n_checks < 12) begin
      miscompares++;
      $display("FAIL check_count: got %0d expected at least 12", n_checks);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
